// File: rtl/tx_queue_scheduler.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tx_queue_scheduler
//
// Sequences the four tx queue FIFOs. Each queue can hold the length of one
// pending packet in 64-bit words. Once a queue's FIFO holds the whole packet,
// the queue is enabled and the medium grants tx, the queue is picked
// round-robin. The scheduler then steers the FIFO read mux (tx_queue_idx) and
// pulses the read enable (ACC_ASK_DATA) exactly once per word of that packet.
//
// Ports
//   clk, rst                 system clock, asynchronous active-high reset
//   data_count0..3           occupancy of queue FIFO 0..3 (words)
//   queue_enable[3:0]        per-queue enable; a disabled queue is never granted
//   pkt_len_wr               1-cycle pulse: load a pending packet length
//   pkt_len_wr_queue[1:0]    target queue of pkt_len_wr
//   pkt_len_wr_num           packet length in words
//   tx_start_ok              medium grant (level), sampled only while idle
//   EMPTYN_TO_ACC            not-empty flag of the currently selected queue
//   overflow_clr             pulse: clears pend_overflow and len_zero_err
//   tx_queue_idx[1:0]        selected queue, held from grant to next grant
//   ACC_ASK_DATA             FIFO read enable toward the selected queue
//   tx_busy                  high whenever a packet is being scheduled
//   tx_done                  1-cycle pulse after the last word is read
//   pend_valid[3:0]          per-queue pending-length-held flags
//   pend_overflow[3:0]       sticky: write dropped, queue already held a length
//   len_zero_err             sticky: zero-length write ignored
// ---------------------------------------------------------------------------
module tx_queue_scheduler #(
    parameter int MAX_BIT_NUM_DMA_SYMBOL = 14
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] data_count0,
    input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] data_count1,
    input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] data_count2,
    input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] data_count3,
    input  logic [3:0]                        queue_enable,
    input  logic                              pkt_len_wr,
    input  logic [1:0]                        pkt_len_wr_queue,
    input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] pkt_len_wr_num,
    input  logic                              tx_start_ok,
    input  logic                              EMPTYN_TO_ACC,
    input  logic                              overflow_clr,
    output logic [1:0]                        tx_queue_idx,
    output logic                              ACC_ASK_DATA,
    output logic                              tx_busy,
    output logic                              tx_done,
    output logic [3:0]                        pend_valid,
    output logic [3:0]                        pend_overflow,
    output logic                              len_zero_err
);

    localparam int W = MAX_BIT_NUM_DMA_SYMBOL;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nx;

    logic [W-1:0]   pend_len   [4];
    logic [W-1:0]   data_count [4];
    logic [W-1:0]   word_cnt;
    logic [1:0]     last;

    logic [3:0]     elig;
    logic [1:0]     winner;
    logic [1:0]     cand;
    logic           found;
    logic           grant;
    logic           rd;

    logic [3:0]     pend_valid_nx;
    logic [3:0]     pend_overflow_nx;
    logic           len_zero_err_nx;
    logic           len_we;

    assign data_count[0] = data_count0;
    assign data_count[1] = data_count1;
    assign data_count[2] = data_count2;
    assign data_count[3] = data_count3;

    // A queue is eligible only when its FIFO already holds the whole packet.
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            elig[i] = pend_valid[i] & queue_enable[i] & (data_count[i] >= pend_len[i]);
        end
    end

    // Round-robin: search last+1, last+2, ... (2-bit add wraps mod 4).
    always_comb begin
        winner = last;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && elig[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign grant = (state == IDLE) & tx_start_ok & found;
    assign rd    = (state == READ) & EMPTYN_TO_ACC & (word_cnt != '0);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state and outputs
    always_comb begin
        state_nx     = state;
        ACC_ASK_DATA = 1'b0;
        tx_busy      = 1'b1;
        tx_done      = 1'b0;
        unique case (state)
            IDLE: begin
                tx_busy = 1'b0;
                if (grant) begin
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                state_nx = READ;
            end
            READ: begin
                ACC_ASK_DATA = rd;
                if (rd && (word_cnt == W'(1))) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                tx_done  = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Pending-length bookkeeping. The grant clears the winner's flag first; a
    // same-cycle write to that queue then re-arms it with the new length while
    // the grant has already latched the old one. Sticky sets win over clear.
    always_comb begin
        pend_valid_nx    = pend_valid;
        pend_overflow_nx = overflow_clr ? '0 : pend_overflow;
        len_zero_err_nx  = overflow_clr ? 1'b0 : len_zero_err;
        len_we           = 1'b0;
        if (grant) begin
            pend_valid_nx[winner] = 1'b0;
        end
        if (pkt_len_wr) begin
            if (pkt_len_wr_num == '0) begin
                len_zero_err_nx = 1'b1;
            end else if (!pend_valid[pkt_len_wr_queue] ||
                         (grant && (winner == pkt_len_wr_queue))) begin
                len_we                          = 1'b1;
                pend_valid_nx[pkt_len_wr_queue] = 1'b1;
            end else begin
                pend_overflow_nx[pkt_len_wr_queue] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_queue_idx  <= '0;
            word_cnt      <= '0;
            last          <= 2'd3;
            pend_valid    <= '0;
            pend_overflow <= '0;
            len_zero_err  <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                pend_len[i] <= '0;
            end
        end else begin
            if (grant) begin
                tx_queue_idx <= winner;
                word_cnt     <= pend_len[winner];
                last         <= winner;
            end else if (rd) begin
                word_cnt <= word_cnt - W'(1);
            end
            if (len_we) begin
                pend_len[pkt_len_wr_queue] <= pkt_len_wr_num;
            end
            pend_valid    <= pend_valid_nx;
            pend_overflow <= pend_overflow_nx;
            len_zero_err  <= len_zero_err_nx;
        end
    end

endmodule

// File: tb/tb_tx_queue_scheduler.sv
`timescale 1ns/1ps
module tb_tx_queue_scheduler;

    localparam int W = 14;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   dc [4];
    logic [3:0]     queue_enable;
    logic           pkt_len_wr;
    logic [1:0]     pkt_len_wr_queue;
    logic [W-1:0]   pkt_len_wr_num;
    logic           tx_start_ok;
    logic           EMPTYN_TO_ACC;
    logic           overflow_clr;
    logic [1:0]     tx_queue_idx;
    logic           ACC_ASK_DATA;
    logic           tx_busy;
    logic           tx_done;
    logic [3:0]     pend_valid;
    logic [3:0]     pend_overflow;
    logic           len_zero_err;

    tx_queue_scheduler #(.MAX_BIT_NUM_DMA_SYMBOL(W)) dut (
        .clk              (clk),
        .rst              (rst),
        .data_count0      (dc[0]),
        .data_count1      (dc[1]),
        .data_count2      (dc[2]),
        .data_count3      (dc[3]),
        .queue_enable     (queue_enable),
        .pkt_len_wr       (pkt_len_wr),
        .pkt_len_wr_queue (pkt_len_wr_queue),
        .pkt_len_wr_num   (pkt_len_wr_num),
        .tx_start_ok      (tx_start_ok),
        .EMPTYN_TO_ACC    (EMPTYN_TO_ACC),
        .overflow_clr     (overflow_clr),
        .tx_queue_idx     (tx_queue_idx),
        .ACC_ASK_DATA     (ACC_ASK_DATA),
        .tx_busy          (tx_busy),
        .tx_done          (tx_done),
        .pend_valid       (pend_valid),
        .pend_overflow    (pend_overflow),
        .len_zero_err     (len_zero_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: packet timeline (cycles since grant, words left)
    logic [W-1:0] m_len [4];
    logic [3:0]   m_pv, m_ovf;
    logic         m_lze;
    int           m_last;
    logic [1:0]   m_idx;
    bit           m_active;
    int           m_t, m_rem;
    bit           m_ask;

    // Observation bookkeeping
    int  cyc = 0;
    bit  prev_busy;
    int  grants[$];
    int  seen_ask, seen_done, first_busy, first_ask, last_ask, done_cyc;

    typedef struct {
        logic [3:0][W-1:0] len;
        logic [3:0][W-1:0] dcv;
        logic [3:0]        en;
        int                exp_q;   // 4 = no grant expected
    } vec_t;
    vec_t vec[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_len[i] = '0;
        m_pv = '0; m_ovf = '0; m_lze = 1'b0; m_last = 3; m_idx = '0;
        m_active = 0; m_t = 0; m_rem = 0; m_ask = 0;
    endtask

    task automatic clr_cnt();
        grants.delete();
        seen_ask = 0; seen_done = 0;
        first_busy = -1; first_ask = -1; last_ask = -1; done_cyc = -1;
    endtask

    task automatic model_check();
        m_ask = m_active && (m_t >= 2) && (m_rem > 0) && EMPTYN_TO_ACC;
        chk("busy",       tx_busy,       m_active);
        chk("ask",        ACC_ASK_DATA,  m_ask);
        chk("done",       tx_done,       m_active && (m_rem == 0));
        chk("idx",        tx_queue_idx,  m_idx);
        chk("pend_valid", pend_valid,    m_pv);
        chk("overflow",   pend_overflow, m_ovf);
        chk("len_zero",   len_zero_err,  m_lze);
    endtask

    task automatic model_edge();
        bit g;
        int w, q;
        logic [3:0] nv;
        g = 0; w = 0;
        if (!m_active && tx_start_ok) begin
            for (int k = 1; k <= 4; k++) begin
                q = (m_last + k) % 4;
                if (!g && m_pv[q] && queue_enable[q] && (dc[q] >= m_len[q])) begin
                    g = 1; w = q;
                end
            end
        end
        if (m_active) begin
            if (m_rem == 0) m_active = 0;
            else begin
                if (m_ask) m_rem--;
                m_t++;
            end
        end
        if (overflow_clr) begin m_ovf = '0; m_lze = 1'b0; end
        nv = m_pv;
        if (g) begin
            m_active = 1; m_t = 1; m_rem = int'(m_len[w]);
            m_idx = w[1:0]; m_last = w; nv[w] = 1'b0;
        end
        if (pkt_len_wr) begin
            q = int'(pkt_len_wr_queue);
            if (pkt_len_wr_num == '0) m_lze = 1'b1;
            else if (!m_pv[q] || (g && w == q)) begin
                m_len[q] = pkt_len_wr_num; nv[q] = 1'b1;
            end else m_ovf[q] = 1'b1;
        end
        m_pv = nv;
    endtask

    // Called right after a falling edge with inputs driven for this cycle.
    task automatic step();
        #1;
        model_check();
        if (tx_busy && !prev_busy) begin
            grants.push_back(int'(tx_queue_idx));
            if (first_busy < 0) first_busy = cyc;
        end
        if (ACC_ASK_DATA) begin
            seen_ask++;
            if (first_ask < 0) first_ask = cyc;
            last_ask = cyc;
        end
        if (tx_done) begin seen_done++; done_cyc = cyc; end
        prev_busy = tx_busy;
        model_edge();
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input int q, input int num);
        pkt_len_wr = 1'b1; pkt_len_wr_queue = q[1:0]; pkt_len_wr_num = num[W-1:0];
        step();
        pkt_len_wr = 1'b0;
    endtask

    task automatic do_reset(input bit mid);
        if (mid) #2;
        rst = 1'b1; pkt_len_wr = 1'b0; overflow_clr = 1'b0;
        #1;
        chk("rst_busy", tx_busy, 0);
        chk("rst_ask",  ACC_ASK_DATA, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_idx",  tx_queue_idx, 0);
        chk("rst_pv",   pend_valid, 0);
        chk("rst_ovf",  pend_overflow, 0);
        chk("rst_lze",  len_zero_err, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        prev_busy = 0;
        clr_cnt();
    endtask

    task automatic set_vec(input int r, input int l0, input int l1, input int l2, input int l3,
                           input int d0, input int d1, input int d2, input int d3,
                           input logic [3:0] en, input int eq);
        vec[r].len[0] = l0[W-1:0]; vec[r].len[1] = l1[W-1:0];
        vec[r].len[2] = l2[W-1:0]; vec[r].len[3] = l3[W-1:0];
        vec[r].dcv[0] = d0[W-1:0]; vec[r].dcv[1] = d1[W-1:0];
        vec[r].dcv[2] = d2[W-1:0]; vec[r].dcv[3] = d3[W-1:0];
        vec[r].en = en; vec[r].exp_q = eq;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 4; i++) dc[i] = '0;
        queue_enable = 4'hF; pkt_len_wr = 0; pkt_len_wr_queue = 0; pkt_len_wr_num = 0;
        tx_start_ok = 0; EMPTYN_TO_ACC = 1; overflow_clr = 0;
        model_reset(); clr_cnt(); prev_busy = 0;
        @(negedge clk);
        do_reset(0);

        // ---- arbitration / eligibility table ----
        set_vec(0, 4, 4, 4, 4,          4, 4, 4, 4,              4'hF, 0);
        set_vec(1, 4, 4, 4, 4,          3, 4, 4, 4,              4'hF, 1);
        set_vec(2, 4, 4, 4, 4,          4, 4, 4, 4,              4'hC, 2);
        set_vec(3, 5, 5, 5, 16383,      0, 0, 0, 16383,          4'hF, 3);
        set_vec(4, 2, 2, 2, 2,          1, 1, 1, 1,              4'hF, 4);
        set_vec(5, 16383, 16383, 16383, 16383, 16382, 16383, 16383, 16383, 4'hF, 1);
        set_vec(6, 'h2001, 1, 1, 1,     'h2000, 0, 0, 1,         4'hF, 3);
        for (int r = 0; r < 7; r++) begin
            do_reset(0);
            queue_enable = vec[r].en;
            for (int q = 0; q < 4; q++) dc[q] = vec[r].dcv[q];
            tx_start_ok = 0;
            for (int q = 0; q < 4; q++) wr(q, int'(vec[r].len[q]));
            tx_start_ok = 1;
            idle(3);
            if (vec[r].exp_q == 4) chk("tbl_busy", tx_busy, 0);
            else begin
                chk("tbl_busy", tx_busy, 1);
                chk("tbl_idx", tx_queue_idx, vec[r].exp_q);
            end
        end

        // ---- 1: basic packet timing ----
        do_reset(0);
        queue_enable = 4'hF; EMPTYN_TO_ACC = 1; dc[0] = 4; tx_start_ok = 0;
        wr(0, 4);
        tx_start_ok = 1;
        idle(12);
        chk("t1_idx", tx_queue_idx, 0);
        chk("t1_asks", seen_ask, 4);
        chk("t1_ask_lat", first_ask - first_busy, 1);
        chk("t1_ask_run", last_ask - first_ask, 3);
        chk("t1_done_lat", done_cyc - first_ask, 4);
        chk("t1_done_cnt", seen_done, 1);
        chk("t1_pv0", pend_valid[0], 0);

        // ---- 2: data_count boundary ----
        do_reset(0);
        dc[1] = 9; tx_start_ok = 1;
        wr(1, 10);
        idle(4);
        chk("t2_nogrant", tx_busy, 0);
        dc[1] = 10;
        step();
        chk("t2_grant", tx_busy, 1);
        chk("t2_idx", tx_queue_idx, 1);
        idle(16);

        // ---- 3: round-robin order ----
        do_reset(0);
        for (int q = 0; q < 4; q++) dc[q] = 8;
        tx_start_ok = 0;
        for (int q = 0; q < 4; q++) wr(q, 2);
        tx_start_ok = 1;
        for (int i = 0; i < 10 && grants.size() == 0; i++) step();
        wr(0, 2);
        idle(50);
        chk("t3_gcount", grants.size(), 5);
        for (int i = 0; i < 5 && i < grants.size(); i++)
            chk("t3_order", grants[i], (i == 4) ? 0 : i);

        do_reset(0);
        queue_enable = 4'b1011; tx_start_ok = 0;
        for (int q = 0; q < 4; q++) wr(q, 2);
        tx_start_ok = 1;
        idle(40);
        chk("t3b_gcount", grants.size(), 3);
        for (int i = 0; i < 3 && i < grants.size(); i++)
            chk("t3b_order", grants[i], (i == 2) ? 3 : i);
        chk("t3b_pv2", pend_valid[2], 1);

        // ---- 4: EMPTYN stall ----
        do_reset(0);
        queue_enable = 4'hF; dc[2] = 3; EMPTYN_TO_ACC = 1; tx_start_ok = 1;
        wr(2, 3);
        for (int i = 0; i < 10 && seen_ask == 0; i++) step();
        EMPTYN_TO_ACC = 0;
        idle(5);
        EMPTYN_TO_ACC = 1;
        idle(10);
        chk("t4_asks", seen_ask, 3);
        chk("t4_done_cnt", seen_done, 1);
        chk("t4_done_after", done_cyc, last_ask + 1);

        // ---- 5: overflow / zero length / clear ----
        do_reset(0);
        dc[3] = 0; tx_start_ok = 0;
        wr(3, 6);
        wr(3, 9);
        chk("t5_ovf3", pend_overflow[3], 1);
        wr(3, 0);
        chk("t5_lze", len_zero_err, 1);
        overflow_clr = 1; step(); overflow_clr = 0;
        chk("t5_clr_ovf", pend_overflow, 0);
        chk("t5_clr_lze", len_zero_err, 0);
        overflow_clr = 1; wr(3, 5); overflow_clr = 0;
        chk("t5_set_wins", pend_overflow[3], 1);
        overflow_clr = 1; step(); overflow_clr = 0;
        dc[3] = 6; tx_start_ok = 1;
        idle(14);
        chk("t5_orig_len", seen_ask, 6);

        // ---- 6: async reset mid-READ ----
        do_reset(0);
        dc[1] = 20; tx_start_ok = 1; EMPTYN_TO_ACC = 1;
        wr(1, 8);
        for (int i = 0; i < 30 && !(m_active && m_t >= 2 && m_rem == 5); i++) step();
        chk("t6_busy_pre", tx_busy, 1);
        do_reset(1);
        idle(4);
        chk("t6_idle", tx_busy, 0);
        chk("t6_nodone", seen_done, 0);

        // ---- randomized run against the model ----
        do_reset(0);
        for (int i = 0; i < 3000; i++) begin
            pkt_len_wr = ($urandom_range(0, 3) == 0);
            pkt_len_wr_queue = 2'($urandom_range(0, 3));
            pkt_len_wr_num = W'($urandom_range(0, 12));
            if ($urandom_range(0, 3) == 0)
                for (int q = 0; q < 4; q++) dc[q] = W'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) queue_enable = 4'($urandom_range(0, 15));
            tx_start_ok = ($urandom_range(0, 2) != 0);
            EMPTYN_TO_ACC = ($urandom_range(0, 3) != 0);
            overflow_clr = ($urandom_range(0, 19) == 0);
            step();
        end
        pkt_len_wr = 0; overflow_clr = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
